// File: rtl/cp0_timer_regfile.sv
// MIPS32 CP0 register subset for the MEM/WB stage: mtc0/mfc0 access with a
// latched read address, Count/Compare timer, interrupt sampling and exception/ERET state.
module cp0_timer_regfile #(
  parameter int unsigned COUNT_DIV   = 2,
  parameter logic [31:0] PRID_VAL    = 32'h0001_8000,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
  parameter logic [31:0] CONFIG_VAL  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  rd,
  input  logic [2:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic        exc_badv_we,
  input  logic [31:0] exc_badv,
  input  logic        eret,
  output logic [31:0] epc_out,
  output logic [31:0] ebase_out,
  output logic        int_req
);

  localparam int          PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  localparam logic [7:0] A_BADV    = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC     = {5'd14, 3'd0};
  localparam logic [7:0] A_PRID    = {5'd15, 3'd0};
  localparam logic [7:0] A_EBASE   = {5'd15, 3'd1};
  localparam logic [7:0] A_CONFIG  = {5'd16, 3'd0};

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d, compare_q, compare_d;
  logic [31:0]   epc_q, epc_d, badv_q, badv_d;
  logic [17:0]   ebase_q, ebase_d;
  logic [7:0]    im_q, im_d, raddr_q, raddr_d;
  logic          exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti_q, ti_d;
  logic [1:0]    ip_sw_q, ip_sw_d;
  logic [5:0]    ip_hw_q;
  logic [4:0]    exc_code_q, exc_code_d;

  logic [7:0]  addr;
  logic [31:0] count_inc;
  logic        presc_wrap;
  logic [7:0]  ip;

  assign addr       = {rd, sel};
  assign count_inc  = count_q + 32'd1;
  assign presc_wrap = (presc_q == PRESC_MAX);
  assign ip         = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

  // NOTE: next state is built with blocking '=' in always_comb and committed with '<=' in always_ff.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
    presc_d    = presc_q;
    count_d    = count_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    badv_d     = badv_q;
    ebase_d    = ebase_q;
    raddr_d    = raddr_q;

    if (we && addr == A_COUNT) begin
      count_d = wdata;
      presc_d = '0;
    end else if (presc_wrap) begin
      count_d = count_inc;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // A Compare write clears TI even when the timer matches on the same cycle.
    if (we && addr == A_COMPARE) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end else if (!(we && addr == A_COUNT) && presc_wrap && count_inc == compare_q) begin
      ti_d = 1'b1;
    end

    if (we && addr == A_STATUS) begin
      im_d  = wdata[15:8];
      exl_d = wdata[1];
      ie_d  = wdata[0];
    end
    if (we && addr == A_CAUSE) ip_sw_d = wdata[9:8];
    if (we && addr == A_EPC)   epc_d   = wdata;
    if (we && addr == A_EBASE) ebase_d = wdata[29:12];

    if (eret) exl_d = 1'b0;
    // A nested exception keeps the original return point in EPC/BD.
    if (exc_valid) begin
      exl_d      = 1'b1;
      exc_code_d = exc_code;
      if (!exl_q) begin
        epc_d = exc_pc;
        bd_d  = exc_bd;
      end
      if (exc_badv_we) badv_d = exc_badv;
    end

    if (re && !we) raddr_d = addr;
  end

  // NOTE: every register here is a flop with an explicit async reset value; there is no memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      ti_q       <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      badv_q     <= '0;
      ebase_q    <= EBASE_RESET[29:12];
      raddr_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      ti_q       <= ti_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= hw_int;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      badv_q     <= badv_d;
      ebase_q    <= ebase_d;
      raddr_q    <= raddr_d;
    end
  end

  assign epc_out   = epc_q;
  assign ebase_out = {EBASE_RESET[31:30], ebase_q, EBASE_RESET[11:0]};
  assign int_req   = ie_q & ~exl_q & |(ip & im_q);

  always_comb begin
    rdata = '0;
    case (raddr_q)
      A_BADV:    rdata = badv_q;
      A_COUNT:   rdata = count_q;
      A_COMPARE: rdata = compare_q;
      A_STATUS:  rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
      A_CAUSE:   rdata = {bd_q, ti_q, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
      A_EPC:     rdata = epc_q;
      A_PRID:    rdata = PRID_VAL;
      A_EBASE:   rdata = ebase_out;
      A_CONFIG:  rdata = CONFIG_VAL;
      default:   rdata = '0;
    endcase
  end

endmodule
